dcache: RTL and testbench

Direct-mapped, write-back data cache between the CPU's memory stage and the word-wide data memory. It takes byte read and write requests from the CPU and answers from its 8 blocks of 4 bytes. On a miss it stalls the CPU with BUSYWAIT, writes back any dirty victim, fetches the missing block and completes the access. It fills the same role for data memory that the register file fills for registers: the responder the CPU reads from and writes to, with the cache now carrying the stall.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_array.sv | 47 ++++
 rtl/dcache.sv | 115 +++++++++++
 tb/tb_dcache.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int TAG_W   = 3;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 2;
    localparam int BLOCK_W = 32;
    localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;
    localparam int SETS    = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_e;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] get_off(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Block storage: data, tag, valid and dirty per set, with a combinational read
// port, a byte-write port for write hits and a whole-block fill port.
module dcache_array
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [BLOCK_W-1:0] rd_data_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    input  logic               wr_en_i,
    input  logic [OFF_W-1:0]   wr_off_i,
    input  logic [7:0]         wr_byte_i,
    input  logic               fill_en_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic [BLOCK_W-1:0] fill_data_i
);

    logic [BLOCK_W-1:0] data_q [SETS];
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;

    assign rd_data_o  = data_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];

    // Data and tag are left unreset; valid=0 makes their contents irrelevant.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            data_q[idx_i]  <= fill_data_i;
            tag_q[idx_i]   <= fill_tag_i;
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            data_q[idx_i][8*wr_off_i +: 8] <= wr_byte_i;
            dirty_q[idx_i]                 <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back data cache: hit/miss logic, miss-handling FSM and
// memory port muxing around the dcache_array storage.
module dcache
    import dcache_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      read_i,
    input  logic                      write_i,
    input  logic [ADDR_W-1:0]         address_i,
    input  logic [7:0]                writedata_i,
    output logic [7:0]                readdata_o,
    output logic                      busywait_o,
    output logic                      mem_read_o,
    output logic                      mem_write_o,
    output logic [TAG_W+IDX_W-1:0]    mem_address_o,
    output logic [BLOCK_W-1:0]        mem_writedata_o,
    input  logic [BLOCK_W-1:0]        mem_readdata_i,
    input  logic                      mem_busywait_i
);

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] fill_q, fill_d;

    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   idx;
    logic [OFF_W-1:0]   off;
    logic [BLOCK_W-1:0] arr_data;
    logic [TAG_W-1:0]   arr_tag;
    logic               arr_valid;
    logic               arr_dirty;
    logic               hit;
    logic               req;
    logic               wr_en;
    logic               fill_en;

    assign tag = get_tag(address_i);
    assign idx = get_idx(address_i);
    assign off = get_off(address_i);
    assign hit = arr_valid && (arr_tag == tag);
    assign req = read_i || write_i;

    dcache_array u_array (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .idx_i       (idx),
        .rd_data_o   (arr_data),
        .rd_tag_o    (arr_tag),
        .rd_valid_o  (arr_valid),
        .rd_dirty_o  (arr_dirty),
        .wr_en_i     (wr_en),
        .wr_off_i    (off),
        .wr_byte_i   (writedata_i),
        .fill_en_i   (fill_en),
        .fill_tag_i  (tag),
        .fill_data_i (fill_q)
    );

    assign readdata_o      = arr_data[8*off +: 8];
    assign mem_writedata_o = arr_data;

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        busywait_o    = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        mem_address_o = {tag, idx};
        wr_en         = 1'b0;
        fill_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // WRITE wins when both strobes are high.
                        wr_en = write_i;
                    end else begin
                        busywait_o = 1'b1;
                        state_d    = (arr_valid && arr_dirty) ? WRITEBACK : FETCH;
                    end
                end
            end
            WRITEBACK: begin
                busywait_o    = 1'b1;
                mem_write_o   = 1'b1;
                mem_address_o = {arr_tag, idx};
                if (!mem_busywait_i) state_d = FETCH;
            end
            FETCH: begin
                busywait_o = 1'b1;
                mem_read_o = 1'b1;
                if (!mem_busywait_i) begin
                    fill_d  = mem_readdata_i;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busywait_o = 1'b1;
                fill_en    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: a latency-L block memory, a CPU-visible byte
// image plus per-set tag/valid/dirty model, and directed access vectors.
module tb_dcache;

    localparam int L = 5;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        read_i, write_i;
    logic [7:0]  address_i, writedata_i, readdata_o;
    logic        busywait_o, mem_read_o, mem_write_o;
    logic [5:0]  mem_address_o;
    logic [31:0] mem_writedata_o, mem_readdata_i;
    logic        mem_busywait_i;

    always #5 clk_i = ~clk_i;

    dcache dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .read_i          (read_i),
        .write_i         (write_i),
        .address_i       (address_i),
        .writedata_i     (writedata_i),
        .readdata_o      (readdata_o),
        .busywait_o      (busywait_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .mem_address_o   (mem_address_o),
        .mem_writedata_o (mem_writedata_o),
        .mem_readdata_i  (mem_readdata_i),
        .mem_busywait_i  (mem_busywait_i)
    );

    // Block memory: busy for the first L-1 cycles of a strobe, completes on the L-th.
    logic [31:0] mem [64];
    int          mem_cnt = 0;
    logic        strobe;

    assign strobe         = mem_read_o || mem_write_o;
    assign mem_busywait_i = strobe && (mem_cnt < L - 1);
    assign mem_readdata_i = mem[mem_address_o];

    always @(posedge clk_i) begin
        if (strobe && mem_cnt == L - 1) begin
            if (mem_write_o) mem[mem_address_o] <= mem_writedata_o;
            mem_cnt <= 0;
        end else if (strobe) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end

    // Reference model: what the CPU should see, and what each set should hold.
    logic [7:0] golden [256];
    logic       mv [8];
    logic [2:0] mt [8];
    logic       md [8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            mv[s] = 1'b0;
            md[s] = 1'b0;
        end
        for (int a = 0; a < 256; a++) golden[a] = mem[a >> 2][8*(a % 4) +: 8];
    endtask

    // Per-cycle checker on every cycle the CPU-side outputs are meaningful.
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni === 1'b1) begin
                if (mem_read_o && mem_write_o) chk("strobe_exclusive", 1, 0);
                if (!busywait_o) begin
                    chk("idle_strobes", {mem_read_o, mem_write_o}, 2'b00);
                    if (read_i && !write_i)
                        chk($sformatf("readdata_0x%02h", address_i), readdata_o, golden[address_i]);
                end
            end
        end
    end

    // One CPU access; checks stall length, memory traffic and read data against the model.
    task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                          output int stall, output logic [5:0] mr_addr, output logic [5:0] mw_addr,
                          output logic [31:0] mw_data, output logic [7:0] rdata);
        logic [2:0]  idx, tg;
        logic        hit, dirty_victim, saw_mr, saw_mw;
        int          exp_stall;
        logic [31:0] victim;
        idx = a[4:2];
        tg  = a[7:5];
        hit = mv[idx] && mt[idx] == tg;
        dirty_victim = !hit && mv[idx] && md[idx];
        exp_stall = hit ? 0 : (dirty_victim ? 2*L + 2 : L + 2);
        for (int k = 0; k < 4; k++) victim[8*k +: 8] = golden[{mt[idx], idx, 2'(k)}];
        saw_mr = 0; saw_mw = 0; mr_addr = 'x; mw_addr = 'x; mw_data = 'x;
        stall = 0;
        @(negedge clk_i);
        read_i = r; write_i = w; address_i = a; writedata_i = d;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            if (mem_read_o && !saw_mr) begin saw_mr = 1; mr_addr = mem_address_o; end
            if (mem_write_o && !saw_mw) begin saw_mw = 1; mw_addr = mem_address_o; mw_data = mem_writedata_o; end
            if (!busywait_o) break;
            stall++;
            @(negedge clk_i);
        end
        rdata = readdata_o;
        chk($sformatf("stall_0x%02h", a), stall, exp_stall);
        chk($sformatf("fetch_seen_0x%02h", a), saw_mr, !hit);
        chk($sformatf("wb_seen_0x%02h", a), saw_mw, dirty_victim);
        if (!hit) chk($sformatf("fetch_addr_0x%02h", a), mr_addr, {tg, idx});
        if (dirty_victim) begin
            chk($sformatf("wb_addr_0x%02h", a), mw_addr, {mt[idx], idx});
            chk($sformatf("wb_data_0x%02h", a), mw_data, victim);
        end
        if (r && !w) chk($sformatf("rdata_0x%02h", a), rdata, golden[a]);
        @(posedge clk_i);
        if (!hit) begin mv[idx] = 1; mt[idx] = tg; md[idx] = 0; end
        if (w) begin md[idx] = 1; golden[a] = d; end
        #1;
        read_i = 0; write_i = 0;
    endtask

    int          st;
    logic [5:0]  mra, mwa;
    logic [31:0] mwd;
    logic [7:0]  rd;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
        mem[0] = 32'h44332211;
        read_i = 0; write_i = 0; address_i = 0; writedata_i = 0;
        rst_ni = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_busy", busywait_o, 0);
        chk("reset_strobes", {mem_read_o, mem_write_o}, 2'b00);
        @(negedge clk_i);
        rst_ni = 1;

        access(1, 0, 8'h00, 8'h00, st, mra, mwa, mwd, rd);
        chk("pin_first_stall", st, 7);
        chk("pin_first_fetch_addr", mra, 6'h00);
        chk("pin_first_rdata", rd, 8'h11);

        access(1, 0, 8'h03, 8'h00, st, mra, mwa, mwd, rd);
        chk("pin_hit_rdata", rd, 8'h44);
        access(0, 1, 8'h01, 8'hAA, st, mra, mwa, mwd, rd);
        access(1, 0, 8'h01, 8'h00, st, mra, mwa, mwd, rd);
        chk("pin_write_hit_rdata", rd, 8'hAA);

        access(1, 0, 8'h20, 8'h00, st, mra, mwa, mwd, rd);
        chk("pin_dirty_stall", st, 12);
        chk("pin_wb_addr", mwa, 6'h00);
        chk("pin_wb_data", mwd, 32'h4433AA11);
        chk("pin_refetch_addr", mra, 6'h08);
        chk("pin_refetch_rdata", rd, 8'h08);

        // Victim from the last fill must be clean: no write-back now.
        access(1, 0, 8'h00, 8'h00, st, mra, mwa, mwd, rd);
        chk("pin_clean_victim_stall", st, 7);
        access(1, 0, 8'h02, 8'h00, st, mra, mwa, mwd, rd);
        access(1, 1, 8'h02, 8'h5A, st, mra, mwa, mwd, rd);
        access(1, 0, 8'h02, 8'h00, st, mra, mwa, mwd, rd);
        chk("pin_rw_precedence", rd, 8'h5A);
        access(1, 0, 8'h20, 8'h00, st, mra, mwa, mwd, rd);
        chk("pin_wb_data2", mwd, 32'h445AAA11);

        access(0, 1, 8'h47, 8'h99, st, mra, mwa, mwd, rd);
        access(1, 0, 8'h47, 8'h00, st, mra, mwa, mwd, rd);
        access(1, 0, 8'hF9, 8'h00, st, mra, mwa, mwd, rd);

        // Reset in the middle of a fetch.
        @(negedge clk_i);
        read_i = 1; address_i = 8'h88;
        repeat (2) @(negedge clk_i);
        #1;
        chk("pin_in_fetch", mem_read_o, 1);
        rst_ni = 0;
        @(posedge clk_i);
        read_i = 0;
        #1;
        chk("abort_strobes", {mem_read_o, mem_write_o}, 2'b00);
        chk("abort_busy", busywait_o, 0);
        @(negedge clk_i);
        rst_ni = 1;
        model_reset();

        access(1, 0, 8'h47, 8'h00, st, mra, mwa, mwd, rd);
        chk("pin_after_reset_miss", st, 7);
        chk("pin_lost_dirty", rd, 8'h14);
        access(1, 0, 8'h00, 8'h00, st, mra, mwa, mwd, rd);
        access(1, 0, 8'h02, 8'h00, st, mra, mwa, mwd, rd);
        chk("pin_after_reset_02", rd, 8'h5A);
        access(1, 0, 8'h88, 8'h00, st, mra, mwa, mwd, rd);

        repeat (3) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
